io_output_reg: RTL and testbench

//   Memory-mapped output side of the CPU I/O subsystem. A store to the output

---
 rtl/io_output_reg.sv | 131 +++++++++++++
 tb/tb_io_output_reg.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/io_output_reg.sv
// Memory-mapped output port block: three 32-bit store-latched ports plus an
// 8-digit multiplexed hex 7-segment scanner driven from port 2.
module io_output_reg #(
  parameter logic [15:0] SCAN_DIV    = 16'd50000,
  parameter logic        SEG_ACT_LOW = 1'b1
) (
  input  logic        io_clk,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  input  logic        write_io_en,
  output logic [31:0] out_port0,
  output logic [31:0] out_port1,
  output logic [31:0] out_port2,
  output logic [31:0] io_rdback,
  output logic [2:0]  port_upd,
  output logic [6:0]  seg,
  output logic [7:0]  an
);

  localparam logic [7:0] AN_OFF  = SEG_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [6:0] SEG_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;

  logic [31:0] r_port0;
  logic [31:0] r_port1;
  logic [31:0] r_port2;
  logic [2:0]  r_upd;
  logic [15:0] r_cnt;
  logic [2:0]  r_digit;
  logic [7:0]  r_an;
  logic [6:0]  r_seg;

  logic [2:0]  w_sel;
  logic [2:0]  w_wr;
  logic        w_wrap;
  logic [3:0]  w_nib;
  logic [7:0]  w_an_on;
  logic [6:0]  w_seg_on;
  logic        w_unused;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign w_unused = ^{addr[31:8], addr[1:0]};

  always_comb begin
    w_sel = 3'b000;
    case (addr[7:2])
      6'b100000: w_sel = 3'b001;
      6'b100001: w_sel = 3'b010;
      6'b100010: w_sel = 3'b100;
      default:   w_sel = 3'b000;
    endcase
  end

  assign w_wr = w_sel & {3{write_io_en}};

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      r_port0 <= 32'h0;
      r_port1 <= 32'h0;
      r_port2 <= 32'h0;
      r_upd   <= 3'b000;
    end else begin
      if (w_wr[0]) r_port0 <= datain;
      if (w_wr[1]) r_port1 <= datain;
      if (w_wr[2]) r_port2 <= datain;
      r_upd <= w_wr;
    end
  end

  // Readback shows registered contents only; a same-cycle store is not forwarded.
  always_comb begin
    io_rdback = 32'h0;
    case (w_sel)
      3'b001:  io_rdback = r_port0;
      3'b010:  io_rdback = r_port1;
      3'b100:  io_rdback = r_port2;
      default: io_rdback = 32'h0;
    endcase
  end

  assign w_wrap   = (r_cnt == SCAN_DIV - 16'd1);
  assign w_nib    = r_port2[{r_digit, 2'b00} +: 4];
  assign w_an_on  = 8'b0000_0001 << r_digit;
  assign w_seg_on = hex7(w_nib);

  // r_digit names the slot loaded into an/seg at the next wrap, so after
  // reset the first refresh (SCAN_DIV cycles in) selects digit 0.
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt   <= 16'd0;
      r_digit <= 3'd0;
      r_an    <= AN_OFF;
      r_seg   <= SEG_OFF;
    end else if (w_wrap) begin
      r_cnt   <= 16'd0;
      r_digit <= r_digit + 3'd1;
      r_an    <= SEG_ACT_LOW ? ~w_an_on  : w_an_on;
      r_seg   <= SEG_ACT_LOW ? ~w_seg_on : w_seg_on;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign out_port0 = r_port0;
  assign out_port1 = r_port1;
  assign out_port2 = r_port2;
  assign port_upd  = r_upd;
  assign an        = r_an;
  assign seg       = r_seg;

endmodule

// File: tb/tb_io_output_reg.sv
// Directed bench for io_output_reg with a short scan period (SCAN_DIV=4).
module tb_io_output_reg;

  logic        io_clk;
  logic        resetn;
  logic [31:0] addr;
  logic [31:0] datain;
  logic        write_io_en;
  logic [31:0] out_port0;
  logic [31:0] out_port1;
  logic [31:0] out_port2;
  logic [31:0] io_rdback;
  logic [2:0]  port_upd;
  logic [6:0]  seg;
  logic [7:0]  an;

  int checks;
  int failures;

  logic [6:0] pat [8];

  io_output_reg #(.SCAN_DIV(16'd4), .SEG_ACT_LOW(1'b1)) dut (
    .io_clk(io_clk), .resetn(resetn), .addr(addr), .datain(datain),
    .write_io_en(write_io_en), .out_port0(out_port0), .out_port1(out_port1),
    .out_port2(out_port2), .io_rdback(io_rdback), .port_upd(port_upd),
    .seg(seg), .an(an)
  );

  initial io_clk = 1'b0;
  always #5 io_clk = ~io_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge io_clk);
      #1;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    pat[0] = 7'h3F; pat[1] = 7'h06; pat[2] = 7'h5B; pat[3] = 7'h4F;
    pat[4] = 7'h66; pat[5] = 7'h6D; pat[6] = 7'h7D; pat[7] = 7'h07;
    resetn = 1'b0;
    addr = 32'h0;
    datain = 32'h0;
    write_io_en = 1'b0;

    // Reset state
    tick(3);
    chk("rst_p0", out_port0, 32'h0);
    chk("rst_p1", out_port1, 32'h0);
    chk("rst_p2", out_port2, 32'h0);
    chk("rst_upd", {29'h0, port_upd}, 32'h0);
    chk("rst_an", {24'h0, an}, 32'hFF);
    chk("rst_seg", {25'h0, seg}, 32'h7F);
    resetn = 1'b1;

    // Store to port 0
    addr = 32'h80; datain = 32'hDEADBEEF; write_io_en = 1'b1;
    tick(1);
    write_io_en = 1'b0;
    chk("w0_port0", out_port0, 32'hDEADBEEF);
    chk("w0_upd", {29'h0, port_upd}, 32'h1);
    chk("w0_rdback", io_rdback, 32'hDEADBEEF);
    tick(1);
    chk("w0_upd_clr", {29'h0, port_upd}, 32'h0);

    // Undecoded store
    addr = 32'h8C; datain = 32'h1234; write_io_en = 1'b1;
    #1;
    chk("ud_rdback_pre", io_rdback, 32'h0);
    tick(1);
    write_io_en = 1'b0;
    chk("ud_upd", {29'h0, port_upd}, 32'h0);
    chk("ud_p0", out_port0, 32'hDEADBEEF);
    chk("ud_p1", out_port1, 32'h0);
    chk("ud_p2", out_port2, 32'h0);
    chk("ud_rdback", io_rdback, 32'h0);

    // Store to port 1 and readback decode
    addr = 32'h84; datain = 32'h5A5A; write_io_en = 1'b1;
    tick(1);
    write_io_en = 1'b0;
    chk("w1_upd", {29'h0, port_upd}, 32'h2);
    chk("w1_rdback", io_rdback, 32'h5A5A);
    addr = 32'h87; #1;
    chk("w1_rdback_lsb", io_rdback, 32'h5A5A);
    addr = 32'hFFFF_FF84; #1;
    chk("w1_rdback_hi", io_rdback, 32'h5A5A);
    addr = 32'h88; #1;
    chk("rd_p2_zero", io_rdback, 32'h0);

    // Same-cycle store not forwarded; back-to-back stores hold port_upd
    addr = 32'h84; datain = 32'h1111; write_io_en = 1'b1;
    #1;
    chk("nofwd_rdback", io_rdback, 32'h5A5A);
    tick(1);
    chk("b2b_p1_a", out_port1, 32'h1111);
    datain = 32'h2222;
    tick(1);
    write_io_en = 1'b0;
    chk("b2b_upd", {29'h0, port_upd}, 32'h2);
    chk("b2b_p1_b", out_port1, 32'h2222);
    tick(1);
    chk("b2b_upd_clr", {29'h0, port_upd}, 32'h0);

    // Display scan: fresh reset, port2 written on edge 1 after release
    #2 resetn = 1'b0;
    #1 resetn = 1'b1;
    addr = 32'h88; datain = 32'h76543210; write_io_en = 1'b1;
    tick(1);
    write_io_en = 1'b0;
    chk("sc_upd2", {29'h0, port_upd}, 32'h4);
    tick(2);
    chk("sc_an_pre", {24'h0, an}, 32'hFF);
    for (int d = 0; d < 8; d++) begin
      tick(1);
      chk($sformatf("sc_an_d%0d", d), {24'h0, an}, {24'h0, ~(8'h01 << d)});
      chk($sformatf("sc_seg_d%0d", d), {25'h0, seg}, {25'h0, ~pat[d]});
      tick(3);
      chk($sformatf("sc_hold_d%0d", d), {24'h0, an}, {24'h0, ~(8'h01 << d)});
    end
    tick(1);
    chk("sc_wrap_an", {24'h0, an}, 32'hFE);
    chk("sc_wrap_seg", {25'h0, seg}, {25'h0, ~pat[0]});

    // Reset mid-scan: 4 more wraps bring the digit counter to 5, then go mid-count
    tick(16 + 2);
    chk("mid_an_pre", {24'h0, an}, 32'hEF);
    #2 resetn = 1'b0;
    #1;
    chk("mid_an_rst", {24'h0, an}, 32'hFF);
    chk("mid_seg_rst", {25'h0, seg}, 32'h7F);
    chk("mid_p2_rst", out_port2, 32'h0);
    @(negedge io_clk);
    resetn = 1'b1;
    tick(3);
    chk("mid_an_wait", {24'h0, an}, 32'hFF);
    tick(1);
    chk("mid_an_d0", {24'h0, an}, 32'hFE);
    chk("mid_seg_d0", {25'h0, seg}, {25'h0, ~pat[0]});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
